// File: rtl/remote_comm.sv
// Robot link: sends a 16-bit command as two 8N1 UART bytes (high byte first)
// and receives 8N1 response bytes; both directions run independently.
module remote_comm #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        cmd_snt,
    output logic        resp_rdy,
    output logic [7:0]  resp
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    // ---------------------------------------------------------------- sender
    typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} tx_state_e;

    tx_state_e       tx_state_q, tx_state_d;
    logic [7:0]      cmd_lo_q,   cmd_lo_d;
    logic [8:0]      tx_sh_q,    tx_sh_d;
    logic            tx_q,       tx_d;
    logic [CW-1:0]   tx_baud_q,  tx_baud_d;
    logic [3:0]      tx_bit_q,   tx_bit_d;
    logic            cmd_snt_q,  cmd_snt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q <= IDLE;
            cmd_lo_q   <= '0;
            tx_sh_q    <= '1;
            tx_q       <= 1'b1;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            cmd_snt_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            cmd_lo_q   <= cmd_lo_d;
            tx_sh_q    <= tx_sh_d;
            tx_q       <= tx_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            cmd_snt_q  <= cmd_snt_d;
        end
    end

    // tx_q carries the current bit; tx_sh_q holds the remaining data+stop bits
    always_comb begin
        tx_state_d = tx_state_q;
        cmd_lo_d   = cmd_lo_q;
        tx_sh_d    = tx_sh_q;
        tx_d       = tx_q;
        tx_baud_d  = tx_baud_q;
        tx_bit_d   = tx_bit_q;
        cmd_snt_d  = cmd_snt_q;
        case (tx_state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (snd_cmd) begin
                    cmd_lo_d   = cmd[7:0];
                    cmd_snt_d  = 1'b0;
                    tx_d       = 1'b0;
                    tx_sh_d    = {1'b1, cmd[15:8]};
                    tx_baud_d  = '0;
                    tx_bit_d   = '0;
                    tx_state_d = SEND_HI;
                end
            end
            SEND_HI, SEND_LO: begin
                if (tx_baud_q == BAUD_LAST) begin
                    tx_baud_d = '0;
                    if (tx_bit_q == 4'd9) begin
                        tx_bit_d = '0;
                        if (tx_state_q == SEND_HI) begin
                            // low byte's start bit follows the stop bit with no gap
                            tx_d       = 1'b0;
                            tx_sh_d    = {1'b1, cmd_lo_q};
                            tx_state_d = SEND_LO;
                        end else begin
                            tx_d       = 1'b1;
                            cmd_snt_d  = 1'b1;
                            tx_state_d = IDLE;
                        end
                    end else begin
                        tx_d     = tx_sh_q[0];
                        tx_sh_d  = {1'b1, tx_sh_q[8:1]};
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end else begin
                    tx_baud_d = tx_baud_q + 1'b1;
                end
            end
            default: begin
                tx_d       = 1'b1;
                tx_state_d = IDLE;
            end
        endcase
    end

    assign TX      = tx_q;
    assign cmd_snt = cmd_snt_q;

    // -------------------------------------------------------------- receiver
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    logic            rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_baud_q,  rx_baud_d;
    logic [2:0]      rx_bit_q,   rx_bit_d;
    logic [7:0]      rx_sh_q,    rx_sh_d;
    logic [7:0]      resp_q,     resp_d;
    logic            resp_rdy_q, resp_rdy_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            resp_q     <= '0;
            resp_rdy_q <= 1'b0;
        end else begin
            rx_s1_q    <= RX;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_baud_q  <= rx_baud_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            resp_q     <= resp_d;
            resp_rdy_q <= resp_rdy_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_baud_d  = rx_baud_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        resp_d     = resp_q;
        resp_rdy_d = resp_rdy_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    resp_rdy_d = 1'b0;
                    rx_baud_d  = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                // a start bit gone high by mid-bit was a glitch
                if (rx_baud_q == HALF_LAST) begin
                    rx_baud_d  = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_baud_d = rx_baud_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_baud_q == BAUD_LAST) begin
                    rx_baud_d = '0;
                    rx_sh_d   = {rx_s2_q, rx_sh_q[7:1]};
                    rx_bit_d  = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    rx_baud_d = rx_baud_q + 1'b1;
                end
            end
            RX_STOP: begin
                // stop level is not checked; the byte is delivered either way
                if (rx_baud_q == BAUD_LAST) begin
                    rx_baud_d  = '0;
                    resp_d     = rx_sh_q;
                    resp_rdy_d = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_baud_d = rx_baud_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign resp     = resp_q;
    assign resp_rdy = resp_rdy_q;

endmodule

// File: tb/tb_remote_comm.sv
// Bench for remote_comm: UART line decoder on TX, UART driver on RX, byte
// scoreboards for both directions, randomized concurrent traffic.
module tb_remote_comm;
    localparam int B = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX, TX;
    logic [15:0] cmd = '0;
    logic        snd_cmd = 1'b0;
    logic        cmd_snt, resp_rdy;
    logic [7:0]  resp;
    logic        rx_drv = 1'b1;
    logic        loop = 1'b0;

    assign RX = loop ? TX : rx_drv;
    always #5 clk = ~clk;

    remote_comm #(.BAUD_DIV(B)) dut (
        .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd),
        .snd_cmd(snd_cmd), .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp)
    );

    int vecs = 0;
    int errs = 0;
    int frame_err = 0;
    logic [7:0] exp_tx[$], got_tx[$], exp_rx[$], got_rx[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // decode TX: every bit must hold the same level for exactly B clocks
    int mcnt, mk, mo;
    bit mbusy = 0;
    logic [9:0] mbits;
    logic mv0;
    initial forever begin
        @(negedge clk);
        if (!rst_n) mbusy = 0;
        else begin
            if (!mbusy && TX === 1'b0) begin mbusy = 1; mcnt = 0; end
            if (mbusy) begin
                mk = mcnt / B;
                mo = mcnt % B;
                if (mo == 0) mv0 = TX;
                if (mo == B - 1) begin
                    if (TX !== mv0) frame_err++;
                    mbits[mk] = TX;
                end
                mcnt++;
                if (mcnt == 10 * B) begin
                    mbusy = 0;
                    if (mbits[0] !== 1'b0 || mbits[9] !== 1'b1) frame_err++;
                    got_tx.push_back(mbits[8:1]);
                end
            end
        end
    end

    logic rr_prev = 1'b0;
    initial forever begin
        @(negedge clk);
        if (resp_rdy === 1'b1 && rr_prev !== 1'b1) got_rx.push_back(resp);
        rr_prev = resp_rdy;
    end

    task automatic uart_send(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        exp_rx.push_back(b);
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            repeat (B) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    // caller is just past a negedge; rp_at < 0 disables the mid-frame re-pulse
    task automatic run_cmd(input logic [15:0] c, input int rp_at, input logic [15:0] rp_val,
                           output int lat);
        int n;
        cmd = c;
        snd_cmd = 1'b1;
        exp_tx.push_back(c[15:8]);
        exp_tx.push_back(c[7:0]);
        @(negedge clk);
        snd_cmd = 1'b0;
        cmd = 16'($urandom);
        n = 1;
        chk("snt_clr", 32'(cmd_snt), 32'd0);
        while (cmd_snt !== 1'b1 && n < 20 * B + 20) begin
            if (n == rp_at) begin cmd = rp_val; snd_cmd = 1'b1; end
            @(negedge clk);
            snd_cmd = 1'b0;
            n++;
            if (n == rp_at + 1) chk("snt_busy", 32'(cmd_snt), 32'd0);
        end
        lat = n - 1;
        chk("latency", 32'(lat >= 20 * B && lat <= 20 * B + 4), 32'd1);
    endtask

    task automatic check_tx();
        chk("tx_count", 32'(got_tx.size()), 32'(exp_tx.size()));
        while (got_tx.size() > 0 && exp_tx.size() > 0)
            chk("tx_byte", 32'(got_tx.pop_front()), 32'(exp_tx.pop_front()));
        got_tx.delete();
        exp_tx.delete();
    endtask

    task automatic check_rx();
        chk("rx_count", 32'(got_rx.size()), 32'(exp_rx.size()));
        while (got_rx.size() > 0 && exp_rx.size() > 0)
            chk("rx_byte", 32'(got_rx.pop_front()), 32'(exp_rx.pop_front()));
        got_rx.delete();
        exp_rx.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, g, rp;
        logic [15:0] c;
        logic [7:0] b;

        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(TX), 32'd1);
        chk("rst_snt", 32'(cmd_snt), 32'd0);
        chk("rst_rdy", 32'(resp_rdy), 32'd0);
        chk("rst_resp", 32'(resp), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd(16'h4004, -1, 16'h0, lat);
        check_tx();
        repeat (10) @(negedge clk);
        chk("snt_hold", 32'(cmd_snt), 32'd1);

        uart_send(8'hA5, 1'b1);
        repeat (2) @(negedge clk);
        chk("a5_resp", 32'(resp), 32'hA5);
        chk("a5_rdy", 32'(resp_rdy), 32'd1);
        check_rx();
        fork
            uart_send(8'h3C, 1'b1);
            begin
                repeat (6) @(negedge clk);
                chk("rdy_clr", 32'(resp_rdy), 32'd0);
                chk("resp_hold", 32'(resp), 32'hA5);
            end
        join
        repeat (2) @(negedge clk);
        check_rx();

        run_cmd(16'h2AB3, 5 * B, 16'hFFFF, lat);
        repeat (2) @(negedge clk);
        check_tx();

        // reset in the middle of the low byte
        cmd = 16'hABCD;
        snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
        repeat (15 * B) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_tx", 32'(TX), 32'd1);
        chk("midrst_snt", 32'(cmd_snt), 32'd0);
        chk("midrst_resp", 32'(resp), 32'd0);
        got_tx.delete();
        exp_tx.delete();
        rst_n = 1'b1;
        run_cmd(16'h0001, -1, 16'h0, lat);
        repeat (2) @(negedge clk);
        check_tx();
        chk("midrst_frm", 32'(frame_err), 32'd0);

        loop = 1'b1;
        run_cmd(16'h5AC3, -1, 16'h0, lat);
        exp_rx.push_back(8'h5A);
        exp_rx.push_back(8'hC3);
        repeat (2) @(negedge clk);
        check_tx();
        check_rx();
        chk("loop_resp", 32'(resp), 32'hC3);
        chk("loop_rdy", 32'(resp_rdy), 32'd1);
        loop = 1'b0;

        g = $urandom_range(2, B / 2 - 2);
        rx_drv = 1'b0;
        repeat (g) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * B) @(negedge clk);
        chk("glitch_rdy", 32'(resp_rdy), 32'd0);
        chk("glitch_resp", 32'(resp), 32'hC3);
        check_rx();

        uart_send(8'h96, 1'b0);
        repeat (2) @(negedge clk);
        chk("stop0_rdy", 32'(resp_rdy), 32'd1);
        check_rx();

        for (int it = 0; it < 8; it++) begin
            c = 16'($urandom);
            b = 8'($urandom);
            rp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(B, 9 * B)) : -1;
            fork
                run_cmd(c, rp, 16'($urandom), lat);
                uart_send(b, 1'b1);
            join
            repeat (4) @(negedge clk);
            check_tx();
            check_rx();
            chk("rand_resp", 32'(resp), 32'(b));
        end

        chk("frame_err", 32'(frame_err), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
